// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction-fetch PC generator driving a 1-cycle-latency SRAM read port
// and tagging each response with its PC (0 = bubble) plus misaligned-fetch status.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] EXC_PC   = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        br_e,
    input  logic [31:0] br_target,
    input  logic        ex_e,
    input  logic [31:0] ex_target,
    input  logic        ex_target_sel,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] pc_o,
    output logic        fetch_adel,
    output logic [31:0] fetch_cnt
);
    logic [31:0] r_fetch_pc;
    logic [31:0] r_pc_o;
    logic        r_adel;
    logic [31:0] r_fetch_cnt;
    logic        r_started;
    logic        w_misaligned;
    logic        w_redirect;
    logic [31:0] w_next_pc;
    logic        w_count;

    assign w_misaligned = r_fetch_pc[1:0] != 2'b00;
    assign w_redirect   = ex_e | br_e;
    // A misaligned PC is never advanced; it waits for a redirect to clear it.
    assign w_next_pc    = ex_e ? (ex_target_sel ? ex_target : EXC_PC) :
                          br_e ? br_target :
                          (stall | w_misaligned) ? r_fetch_pc : r_fetch_pc + 32'd4;
    assign w_count      = r_started & ~stall & ~w_redirect & (r_pc_o != 32'd0) & ~r_adel;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fetch_pc  <= RESET_PC;
            r_pc_o      <= 32'd0;
            r_adel      <= 1'b0;
            r_fetch_cnt <= 32'd0;
            r_started   <= 1'b0;
        end else begin
            r_fetch_pc  <= w_next_pc;
            r_pc_o      <= w_redirect ? 32'd0 : r_fetch_pc;
            r_adel      <= ~w_redirect & w_misaligned;
            r_fetch_cnt <= r_fetch_cnt + {31'd0, w_count};
            r_started   <= 1'b1;
        end
    end

    assign inst_sram_en    = resetn & ~w_misaligned;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = r_fetch_pc;
    assign inst_sram_wdata = 32'b0;
    assign pc_o            = r_pc_o;
    assign fetch_adel      = r_adel;
    assign fetch_cnt       = r_fetch_cnt;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vectors with hand-computed expectations for fetch_pc_gen.
module tb_fetch_pc_gen;
    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic        br_e;
    logic [31:0] br_target;
    logic        ex_e;
    logic [31:0] ex_target;
    logic        ex_target_sel;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] pc_o;
    logic        fetch_adel;
    logic [31:0] fetch_cnt;
    int          checks = 0;
    int          errors = 0;

    fetch_pc_gen dut (
        .clk(clk), .resetn(resetn), .stall(stall), .br_e(br_e), .br_target(br_target),
        .ex_e(ex_e), .ex_target(ex_target), .ex_target_sel(ex_target_sel),
        .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .pc_o(pc_o), .fetch_adel(fetch_adel), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                      input logic en, input logic adel, input logic [31:0] cnt);
        chk({tag, ".addr"}, inst_sram_addr, addr);
        chk({tag, ".pc"}, pc_o, pc);
        chk({tag, ".en"}, {31'd0, inst_sram_en}, {31'd0, en});
        chk({tag, ".adel"}, {31'd0, fetch_adel}, {31'd0, adel});
        chk({tag, ".cnt"}, fetch_cnt, cnt);
        chk({tag, ".we"}, {28'd0, inst_sram_we}, 32'd0);
        chk({tag, ".wd"}, inst_sram_wdata, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; stall = 1'b0; br_e = 1'b0; br_target = 32'd0;
        ex_e = 1'b0; ex_target = 32'd0; ex_target_sel = 1'b0;
        repeat (3) tick();
        st("rst", 32'hBFC00000, 32'd0, 1'b0, 1'b0, 32'd0);
        resetn = 1'b1;
        #1;
        st("c0", 32'hBFC00000, 32'd0, 1'b1, 1'b0, 32'd0);
        tick(); st("c1", 32'hBFC00004, 32'hBFC00000, 1'b1, 1'b0, 32'd0);
        tick(); st("c2", 32'hBFC00008, 32'hBFC00004, 1'b1, 1'b0, 32'd1);
        tick(); st("c3", 32'hBFC0000C, 32'hBFC00008, 1'b1, 1'b0, 32'd2);
        tick(); st("c4", 32'hBFC00010, 32'hBFC0000C, 1'b1, 1'b0, 32'd3);
        stall = 1'b1;
        tick(); st("stl1", 32'hBFC00010, 32'hBFC00010, 1'b1, 1'b0, 32'd3);
        tick(); st("stl2", 32'hBFC00010, 32'hBFC00010, 1'b1, 1'b0, 32'd3);
        tick(); st("stl3", 32'hBFC00010, 32'hBFC00010, 1'b1, 1'b0, 32'd3);
        stall = 1'b0;
        tick(); st("rel1", 32'hBFC00014, 32'hBFC00010, 1'b1, 1'b0, 32'd4);
        tick(); st("rel2", 32'hBFC00018, 32'hBFC00014, 1'b1, 1'b0, 32'd5);
        tick(); tick();
        st("pre_br", 32'hBFC00020, 32'hBFC0001C, 1'b1, 1'b0, 32'd7);
        br_e = 1'b1; br_target = 32'hBFC00100;
        tick(); st("br1", 32'hBFC00100, 32'd0, 1'b1, 1'b0, 32'd7);
        br_e = 1'b0;
        tick(); st("br2", 32'hBFC00104, 32'hBFC00100, 1'b1, 1'b0, 32'd7);
        ex_e = 1'b1; ex_target_sel = 1'b0; ex_target = 32'h12345678;
        br_e = 1'b1; br_target = 32'hBFC00200; stall = 1'b1;
        tick(); st("ex0", 32'hBFC00380, 32'd0, 1'b1, 1'b0, 32'd7);
        br_e = 1'b0; stall = 1'b0; ex_target_sel = 1'b1; ex_target = 32'h80001000;
        tick(); st("ex1", 32'h80001000, 32'd0, 1'b1, 1'b0, 32'd7);
        ex_e = 1'b0;
        tick(); st("ex2", 32'h80001004, 32'h80001000, 1'b1, 1'b0, 32'd7);
        br_e = 1'b1; br_target = 32'hBFC00102;
        tick(); st("mis1", 32'hBFC00102, 32'd0, 1'b0, 1'b0, 32'd7);
        br_e = 1'b0;
        tick(); st("mis2", 32'hBFC00102, 32'hBFC00102, 1'b0, 1'b1, 32'd7);
        tick(); st("mis3", 32'hBFC00102, 32'hBFC00102, 1'b0, 1'b1, 32'd7);
        ex_e = 1'b1; ex_target_sel = 1'b0;
        tick(); st("mis_ex", 32'hBFC00380, 32'd0, 1'b1, 1'b0, 32'd7);
        ex_e = 1'b0;
        tick(); st("mis_ok", 32'hBFC00384, 32'hBFC00380, 1'b1, 1'b0, 32'd7);
        stall = 1'b1;
        tick(); st("srst0", 32'hBFC00384, 32'hBFC00384, 1'b1, 1'b0, 32'd7);
        resetn = 1'b0;
        tick(); st("srst1", 32'hBFC00000, 32'd0, 1'b0, 1'b0, 32'd0);
        resetn = 1'b1; stall = 1'b0; br_e = 1'b1; br_target = 32'hFFFFFFFC;
        tick(); st("wrap1", 32'hFFFFFFFC, 32'd0, 1'b1, 1'b0, 32'd0);
        br_e = 1'b0;
        tick(); st("wrap2", 32'h00000000, 32'hFFFFFFFC, 1'b1, 1'b0, 32'd0);
        tick(); st("wrap3", 32'h00000004, 32'd0, 1'b1, 1'b0, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Instruction-fetch front end: owns the fetch PC, drives the instruction SRAM request port, and presents the PC tag that travels with inst_sram_rdata into the decoder stage.
- Honours the decoder's stall/flush protocol: stall holds, br_e redirects. pc_o == 0 marks "no valid instruction", which the decoder treats as a bubble.
- Also handles exception redirect and misaligned-fetch (AdEL) tagging.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset.
EXC_PC, 32'hBFC0_0380, default exception vector (used when ex_target_sel=0).

Ports:
clk  in  1  clock.
resetn  in  1  synchronous, active-low reset.
stall  in  1  back-pressure from decode/scoreboard; hold fetch.
br_e  in  1  branch redirect taken this cycle.
br_target  in  32  redirect address, valid with br_e.
ex_e  in  1  exception/eret redirect; priority over br_e.
ex_target  in  32  explicit exception/eret target.
ex_target_sel  in  1  1 = use ex_target, 0 = use EXC_PC.
inst_sram_en  out  1  SRAM read request enable.
inst_sram_we  out  4  always 4'b0.
inst_sram_addr  out  32  request address = fetch_pc.
inst_sram_wdata  out  32  always 32'b0.
pc_o  out  32  PC tag aligned with inst_sram_rdata this cycle; 0 = invalid.
fetch_adel  out  1  pc_o is misaligned (AdEL); data must be discarded.
fetch_cnt  out  32  count of valid instructions accepted by decode (performance).

Behaviour:
- SRAM read latency is 1 cycle: rdata in cycle t+1 belongs to the address issued in cycle t. pc_o is a register that tags that response.
- State:
  - fetch_pc (32).
  - pc_o (32).
  - adel_r (1).
  - fetch_cnt (32).
  - First-cycle flag started (1): 0 during reset, 1 from the first cycle after reset.
- Reset (resetn = 0 at posedge) overrides everything:
  - fetch_pc = RESET_PC, pc_o = 0, adel_r = 0, fetch_cnt = 0, started = 0.
  - inst_sram_en = 0 while resetn = 0.
  - Reset mid-stall or mid-redirect discards all pending state.
- inst_sram_en = resetn & (fetch_pc[1:0] == 2'b00). Misaligned addresses are never sent to SRAM.
- Next-state priority, evaluated per cycle:
  1. ex_e:
     - fetch_pc <= ex_target_sel ? ex_target : EXC_PC.
     - pc_o <= 0, adel_r <= 0.
  2. br_e:
     - fetch_pc <= br_target.
     - pc_o <= 0, adel_r <= 0. The response to the wrong-path request issued this cycle is killed.
  3. stall:
     - fetch_pc holds.
     - pc_o <= fetch_pc and adel_r <= (fetch_pc[1:0] != 0). The request is re-issued every stall cycle; decode ignores these responses while stalled.
  4. Otherwise:
     - fetch_pc <= fetch_pc + 4, with 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000).
     - pc_o <= fetch_pc, adel_r <= (fetch_pc[1:0] != 0).
- Stall release:
  - The cycle stall deasserts, the request for the held fetch_pc is issued again.
  - Its response arrives next cycle tagged with that PC. Decode has meanwhile consumed its own buffered instruction, so no instruction is lost or duplicated.
- fetch_adel = adel_r.
  - When adel_r = 1, pc_o carries the faulting PC and inst_sram_rdata is don't-care.
  - fetch_pc does not advance past a misaligned PC. It holds until ex_e or br_e.
- fetch_cnt increments by 1 in any cycle where all of the following hold:
  - ~stall, ~br_e, ~ex_e.
  - pc_o != 0 and ~adel_r.
  - It wraps at 2^32.
- Simultaneous ex_e & br_e & stall: ex_e wins. Redirects are never blocked by stall.
- Redirect to address 0: allowed. pc_o then reads 0 and the slot is treated as a bubble (documented limitation).
- inst_sram_we and inst_sram_wdata are constant 0 in all states.

Test Plan:
- Reset release:
  - resetn low 3 cycles, then high.
  - Cycle 0 after release: addr = BFC00000, en = 1, pc_o = 0.
  - Cycle 1: addr = BFC00004, pc_o = BFC00000.
  - Cycle 2: pc_o = BFC00004.
  - fetch_cnt = 2 after cycle 2.
- Stall:
  - Stall asserted 3 cycles with fetch_pc = BFC00010.
  - addr stays BFC00010 for all 3 cycles; pc_o = BFC00010 during the stall.
  - After release: pc_o sequence BFC00010, BFC00014; no address skipped.
  - fetch_cnt unchanged during the stall.
- Branch redirect:
  - br_e = 1, br_target = BFC00100 at fetch_pc = BFC00020.
  - Next cycle: pc_o = 0, addr = BFC00100.
  - Following cycle: pc_o = BFC00100.
- Exception priority:
  - ex_e = 1 (sel = 0) with br_e = 1 and stall = 1.
  - addr = BFC00380 next cycle, pc_o = 0.
  - With sel = 1 and ex_target = 80001000: addr = 80001000.
- Misaligned target:
  - br_target = BFC00102.
  - en = 0, next pc_o = BFC00102 with fetch_adel = 1.
  - fetch_pc holds until ex_e to BFC00380; then fetch_adel = 0.
- Mid-stall reset and wrap:
  - resetn low during a stall: next cycle fetch_pc = BFC00000, pc_o = 0.
  - Redirect to FFFFFFFC: addr sequence FFFFFFFC then 00000000.
